// File: rtl/alu_operand_stage_pkg.sv
// Shared encodings for the ALU operand stage: operand selects, ALU ops,
// skid-buffer states and the default-width buffered entry layout.
package alu_operand_stage_pkg;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;

  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;
  localparam logic [1:0] B_ZERO = 2'd3;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_REGW  = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_XOR = 3'd2,
    ALU_OR  = 3'd3,
    ALU_AND = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SRA = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_SKID  = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] in1;
    logic [DEF_WIDTH-1:0] in2;
    logic [2:0]           sel;
    logic [DEF_REGW-1:0]  rd;
  } entry_t;

endpackage

// File: rtl/alu_operand_stage_skid_buffer.sv
// Two-entry skid buffer: one output register plus one skid register, with
// in_ready taken straight from registered state so it never depends on out_ready.
module alu_operand_stage_skid_buffer
  import alu_operand_stage_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e state;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         consume;

  assign in_ready  = (state != ST_SKID);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;

  // Flush drops everything, including a same-cycle accept; data regs may go stale.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      out_data  <= '0;
      skid_data <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            out_data <= in_data;
            state    <= ST_MAIN;
          end
        end
        ST_MAIN: begin
          if (accept && !consume) begin
            skid_data <= in_data;
            state     <= ST_SKID;
          end else if (accept && consume) begin
            out_data <= in_data;
          end else if (consume) begin
            state <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (consume) begin
            out_data <= skid_data;
            state    <= ST_MAIN;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand stage ahead of the ALU: resolves sources with writeback forwarding,
// muxes operands A/B and hands the entry to the ALU through a skid buffer.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REGW  = DEF_REGW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REGW-1:0]  rs1_idx,
  input  logic [REGW-1:0]  rs2_idx,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  input  logic [1:0]       a_sel,
  input  logic [1:0]       b_sel,
  input  logic [2:0]       alu_sel,
  input  logic [REGW-1:0]  rd_idx,
  input  logic             wb_en,
  input  logic [REGW-1:0]  wb_idx,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] in2,
  output logic [2:0]       sel,
  output logic [REGW-1:0]  rd_out
);

  localparam int ENTRY_W = 2 * WIDTH + 3 + REGW;

  logic [WIDTH-1:0]   src1;
  logic [WIDTH-1:0]   src2;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [ENTRY_W-1:0] new_entry;
  logic [ENTRY_W-1:0] head_entry;

  // Forwarding happens only here at capture; buffered entries are never re-forwarded.
  always_comb begin
    src1 = rs1_data;
    src2 = rs2_data;
    if (rs1_idx == '0)
      src1 = '0;
    else if (wb_en && (wb_idx == rs1_idx))
      src1 = wb_data;
    if (rs2_idx == '0)
      src2 = '0;
    else if (wb_en && (wb_idx == rs2_idx))
      src2 = wb_data;
  end

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (a_sel)
      A_RS1:   op_a = src1;
      A_PC:    op_a = pc;
      default: op_a = '0;
    endcase
    case (b_sel)
      B_RS2:   op_b = src2;
      B_IMM:   op_b = imm;
      B_FOUR:  op_b = WIDTH'(4);
      default: op_b = '0;
    endcase
  end

  assign new_entry = {op_a, op_b, alu_sel, rd_idx};
  assign {in1, in2, sel, rd_out} = head_entry;

  alu_operand_stage_skid_buffer #(
    .W(ENTRY_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (new_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_entry)
  );

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed plus short randomized bench for alu_operand_stage; a scoreboard queue
// holds expected entries from acceptance until the DUT hands them to the ALU.
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [1:0]  a_sel;
  logic [1:0]  b_sel;
  logic [2:0]  alu_sel;
  logic [4:0]  rd_idx;
  logic        wb_en;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [2:0]  sel;
  logic [4:0]  rd_out;

  entry_t scoreboard[$];
  int     n_checks;
  int     n_fail;

  alu_operand_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rs1_idx   (rs1_idx),
    .rs2_idx   (rs2_idx),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .pc        (pc),
    .imm       (imm),
    .a_sel     (a_sel),
    .b_sel     (b_sel),
    .alu_sel   (alu_sel),
    .rd_idx    (rd_idx),
    .wb_en     (wb_en),
    .wb_idx    (wb_idx),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in1       (in1),
    .in2       (in2),
    .sel       (sel),
    .rd_out    (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] r1i, input logic [31:0] r1d,
                               input logic [4:0] r2i, input logic [31:0] r2d,
                               input logic [31:0] pcv, input logic [31:0] immv,
                               input logic [1:0] as, input logic [1:0] bs,
                               input logic [2:0] op, input logic [4:0] rd);
    in_valid = v;
    rs1_idx  = r1i;
    rs1_data = r1d;
    rs2_idx  = r2i;
    rs2_data = r2d;
    pc       = pcv;
    imm      = immv;
    a_sel    = as;
    b_sel    = bs;
    alu_sel  = op;
    rd_idx   = rd;
  endtask

  // Reference operand selection for whatever decode is presenting right now.
  function automatic entry_t modelEntry();
    entry_t e;
    logic [31:0] s1;
    logic [31:0] s2;
    if (rs1_idx == 5'd0)                     s1 = 32'd0;
    else if (wb_en && (wb_idx == rs1_idx))   s1 = wb_data;
    else                                     s1 = rs1_data;
    if (rs2_idx == 5'd0)                     s2 = 32'd0;
    else if (wb_en && (wb_idx == rs2_idx))   s2 = wb_data;
    else                                     s2 = rs2_data;
    e.in1 = (a_sel == 2'd0) ? s1 : (a_sel == 2'd1) ? pc : 32'd0;
    case (b_sel)
      2'd0:    e.in2 = s2;
      2'd1:    e.in2 = imm;
      2'd2:    e.in2 = 32'd4;
      default: e.in2 = 32'd0;
    endcase
    e.sel = alu_sel;
    e.rd  = rd_idx;
    return e;
  endfunction

  // One clock: check handshake flags against the model occupancy, retire and
  // capture entries on the falling edge, then step past the rising edge.
  task automatic runCycle();
    logic   acc;
    logic   con;
    entry_t exp_e;
    @(negedge clk);
    checkOutput("out_valid", 32'(out_valid), 32'(scoreboard.size() != 0));
    checkOutput("in_ready", 32'(in_ready), 32'(scoreboard.size() < 2));
    if (rst_n && !flush) begin
      con = (scoreboard.size() != 0) && out_ready;
      acc = in_valid && (scoreboard.size() < 2);
      if (con) begin
        exp_e = scoreboard.pop_front();
        checkOutput("in1", in1, exp_e.in1);
        checkOutput("in2", in2, exp_e.in2);
        checkOutput("sel", 32'(sel), 32'(exp_e.sel));
        checkOutput("rd_out", 32'(rd_out), 32'(exp_e.rd));
      end
      if (acc) scoreboard.push_back(modelEntry());
    end else begin
      scoreboard.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_in1"}, in1, 32'd0);
    checkOutput({tag, "_in2"}, in2, 32'd0);
    checkOutput({tag, "_sel"}, 32'(sel), 32'd0);
    checkOutput({tag, "_rd"}, 32'(rd_out), 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    wb_en     = 1'b0;
    wb_idx    = 5'd0;
    wb_data   = 32'd0;
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 3'd0, 5'd0);

    // Reset, then idle with in_valid low.
    repeat (2) @(posedge clk);
    #1;
    checkZeroOutputs("reset");
    rst_n = 1'b1;
    repeat (3) runCycle();

    // Simple issue: in1=5, in2=7, sel=SUB, gone again one cycle later.
    out_ready = 1'b1;
    applyStimulus(1'b1, 5'd1, 32'd5, 5'd2, 32'd7, 32'h100, 32'd0, A_RS1, B_RS2, ALU_SUB, 5'd10);
    runCycle();
    in_valid = 1'b0;
    checkOutput("issue_in1", in1, 32'd5);
    checkOutput("issue_in2", in2, 32'd7);
    runCycle();
    runCycle();

    // Writeback forwarding on rs1 and x0 on rs2, then wb_idx=0 must not forward.
    wb_en   = 1'b1;
    wb_idx  = 5'd3;
    wb_data = 32'h0000DEAD;
    applyStimulus(1'b1, 5'd3, 32'd1, 5'd0, 32'd9, 32'h0, 32'd0, A_RS1, B_RS2, ALU_XOR, 5'd4);
    runCycle();
    in_valid = 1'b0;
    checkOutput("fwd_in1", in1, 32'h0000DEAD);
    checkOutput("fwd_in2", in2, 32'd0);
    runCycle();
    wb_idx = 5'd0;
    applyStimulus(1'b1, 5'd3, 32'd1, 5'd0, 32'd9, 32'h0, 32'd0, A_RS1, B_RS2, ALU_XOR, 5'd4);
    runCycle();
    in_valid = 1'b0;
    checkOutput("nofwd_in1", in1, 32'd1);
    runCycle();
    wb_en = 1'b0;

    // Backpressure: A and B fill the buffer, C waits, then all drain in order.
    out_ready = 1'b0;
    applyStimulus(1'b1, 5'd1, 32'h11, 5'd2, 32'h22, 32'h80000000, 32'd0, A_PC, B_FOUR, ALU_ADD, 5'd1);
    runCycle();
    applyStimulus(1'b1, 5'd5, 32'h55, 5'd6, 32'h66, 32'h80000004, 32'hFFFFFFF0, A_RS1, B_IMM, ALU_AND, 5'd2);
    runCycle();
    checkOutput("bp_in1", in1, 32'h80000000);
    checkOutput("bp_in2", in2, 32'd4);
    checkOutput("bp_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 5'd7, 32'h77, 5'd8, 32'h88, 32'h80000008, 32'd0, A_ZERO, B_ZERO, ALU_SRA, 5'd3);
    repeat (2) runCycle();
    out_ready = 1'b1;
    repeat (2) runCycle();
    in_valid = 1'b0;
    repeat (2) runCycle();

    // Flush while in SKID with a new instruction presented: all of it is dropped.
    out_ready = 1'b0;
    applyStimulus(1'b1, 5'd1, 32'hA1, 5'd2, 32'hA2, 32'h0, 32'd0, A_RS1, B_RS2, ALU_OR, 5'd5);
    runCycle();
    applyStimulus(1'b1, 5'd1, 32'hB1, 5'd2, 32'hB2, 32'h0, 32'd0, A_RS1, B_RS2, ALU_OR, 5'd6);
    runCycle();
    flush = 1'b1;
    applyStimulus(1'b1, 5'd1, 32'hD1, 5'd2, 32'hD2, 32'h0, 32'd0, A_RS1, B_RS2, ALU_SLL, 5'd7);
    runCycle();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) runCycle();

    // Reset in the middle of SKID, then a fresh issue.
    out_ready = 1'b0;
    applyStimulus(1'b1, 5'd9, 32'hC1, 5'd10, 32'hC2, 32'h0, 32'd0, A_RS1, B_RS2, ALU_SRL, 5'd8);
    repeat (2) runCycle();
    rst_n = 1'b0;
    runCycle();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    checkZeroOutputs("midrst");
    out_ready = 1'b1;
    applyStimulus(1'b1, 5'd2, 32'h1234, 5'd3, 32'h5678, 32'h40, 32'h7, A_PC, B_IMM, ALU_ADD, 5'd9);
    runCycle();
    in_valid = 1'b0;
    repeat (2) runCycle();

    // Randomized traffic with forwarding and backpressure.
    for (int i = 0; i < 80; i++) begin
      wb_en     = 1'($urandom_range(0, 1));
      wb_idx    = 5'($urandom_range(0, 3));
      wb_data   = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                    5'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      runCycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) runCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
